// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared defaults, zero-register index and address type for the register bank
package banco_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int NUM_RD_DEF = 2;

    // Architectural zero register: never written, never reserved, always reads 0.
    localparam int REG_ZERO = 0;

    typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/banco_rd_port.sv
// rtl/banco_rd_port.sv - one combinational read port (mux, zero check, optional write bypass via BANCO_REGISTROS_BYPASS_EN)
module banco_rd_port
    import banco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           rst_n,
    input  logic [DEPTH-1:0][DATA_W-1:0]   mem,
    input  logic [DEPTH-1:0]               busy,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              wa,
    input  logic [DATA_W-1:0]              wd,
    input  logic [ADDR_W-1:0]              ra,
    output logic [DATA_W-1:0]              rd,
    output logic                           rbusy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

`ifndef BANCO_REGISTROS_BYPASS_EN
    // Write-port inputs only matter when forwarding is compiled in.
    logic unused_wr;
    assign unused_wr = ^{we, wa, wd};
`endif

    // Select stored value, optionally forward the in-flight write, then force zero for r0 and during reset.
    always_comb begin
        rd    = mem[ra];
        rbusy = busy[ra];
`ifdef BANCO_REGISTROS_BYPASS_EN
        if (we && (wa == ra)) begin
            rd    = wd;
            rbusy = 1'b0;
        end
`endif
        // Zero register and reset override everything, including the bypass.
        if ((ra == ZERO_ADDR) || !rst_n) begin
            rd    = '0;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/banco_registros_sb.sv
// rtl/banco_registros_sb.sv - register bank with busy scoreboard; optional same-cycle write bypass via BANCO_REGISTROS_BYPASS_EN
module banco_registros_sb
    import banco_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wa,
    input  logic [DATA_W-1:0]         wd,
    input  logic                      rsv,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]  ra,
    output logic [NUM_RD*DATA_W-1:0]  rd,
    output logic [NUM_RD-1:0]         rbusy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;

    // Next storage state: write-back clears busy, then a reserve sets it (reserve is the newer producer).
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we && (wa != ZERO_ADDR)) begin
            mem_d[wa]  = wd;
            busy_d[wa] = 1'b0;
        end
        if (rsv && (rsv_addr != ZERO_ADDR)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Storage and scoreboard registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        banco_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_port (
            .rst_n (rst_n),
            .mem   (mem_q),
            .busy  (busy_q),
            .we    (we),
            .wa    (wa),
            .wd    (wd),
            .ra    (ra[k*ADDR_W +: ADDR_W]),
            .rd    (rd[k*DATA_W +: DATA_W]),
            .rbusy (rbusy[k])
        );
    end

endmodule

// File: tb/tb_banco_registros_sb.sv
// tb/tb_banco_registros_sb.sv - self-checking bench for banco_registros_sb (default build or BANCO_REGISTROS_BYPASS_EN)
module tb_banco_registros_sb;
    import banco_pkg::*;

`ifdef BANCO_REGISTROS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    reg_addr_t         wa;
    logic [31:0]       wd;
    logic              rsv;
    reg_addr_t         rsv_addr;
    logic [9:0]        ra;
    logic [63:0]       rd;
    logic [1:0]        rbusy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem  [32];
    logic        m_busy [32];

    always #5 clk = ~clk;

    banco_registros_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy)
    );

    typedef struct {
        logic        we;
        reg_addr_t   wa;
        logic [31:0] wd;
        logic        rsv;
        reg_addr_t   rsv_addr;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input reg_addr_t a, input logic [31:0] d,
                         input logic r, input reg_addr_t ra_r, input reg_addr_t r0, input reg_addr_t r1);
        we = w; wa = a; wd = d; rsv = r; rsv_addr = ra_r; ra = {r1, r0};
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Advance one clock; the reference arrays take the architectural effect of the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 1'b0;
        end
        if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input reg_addr_t a);
        if (a == 0) return '0;
        if (BYP && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input reg_addr_t a);
        if (a == 0) return 1'b0;
        if (BYP && we && wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    initial begin
        // Vectors avoid reading the address being written, so they hold for both builds.
        vecs[0]  = '{1, 3,  32'hDEADBEEF, 0, 0,  1,  2,  32'h0,        32'h0,        2'b00};
        vecs[1]  = '{0, 0,  32'h0,        1, 7,  3,  7,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  7,  3,  32'h0,        32'hDEADBEEF, 2'b01};
        vecs[3]  = '{1, 7,  32'h12,       0, 0,  3,  0,  32'hDEADBEEF, 32'h0,        2'b00};
        vecs[4]  = '{0, 0,  32'h0,        0, 0,  7,  7,  32'h12,       32'h12,       2'b00};
        vecs[5]  = '{1, 0,  32'hFFFFFFFF, 1, 0,  0,  3,  32'h0,        32'hDEADBEEF, 2'b00};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        2'b00};
        vecs[7]  = '{1, 9,  32'h55,       1, 9,  1,  3,  32'h0,        32'hDEADBEEF, 2'b00};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  9,  9,  32'h55,       32'h55,       2'b11};
        vecs[9]  = '{1, 12, 32'hAA,       1, 13, 9,  7,  32'h55,       32'h12,       2'b01};
        vecs[10] = '{0, 0,  32'h0,        0, 0,  12, 13, 32'hAA,       32'h0,        2'b10};
        vecs[11] = '{1, 9,  32'h66,       0, 0,  13, 12, 32'h0,        32'hAA,       2'b01};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  9,  4,  32'h66,       32'h0,        2'b00};

        model_clear();
        rst_n = 1'b0;
        drive(1, 3, 32'hCAFE0000, 1, 3, 3, 0);
        #1;
        chk("reset rd0", rd[31:0], 32'h0);
        chk("reset rbusy", {30'h0, rbusy}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rsv, vecs[i].rsv_addr, vecs[i].ra0, vecs[i].ra1);
            @(negedge clk);
            chk($sformatf("vec%0d rd0", i), rd[31:0], vecs[i].e_rd0);
            chk($sformatf("vec%0d rd1", i), rd[63:32], vecs[i].e_rd1);
            chk($sformatf("vec%0d rbusy", i), {30'h0, rbusy}, {30'h0, vecs[i].e_busy});
            tick();
        end

        // Both ports read register 4 while it is being written.
        drive(1, 4, 32'h11, 0, 0, 1, 2);
        tick();
        drive(1, 4, 32'hA5, 0, 0, 4, 4);
        @(negedge clk);
        chk("same-cycle rd0", rd[31:0], BYP ? 32'hA5 : 32'h11);
        chk("same-cycle rd1", rd[63:32], BYP ? 32'hA5 : 32'h11);
        chk("same-cycle rbusy", {30'h0, rbusy}, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 4);
        @(negedge clk);
        chk("next-cycle rd0", rd[31:0], 32'hA5);
        chk("next-cycle rd1", rd[63:32], 32'hA5);
        tick();

        // Random traffic, addresses biased low so writes, reserves and reads collide often.
        for (int n = 0; n < 400; n++) begin
            reg_addr_t a_w, a_r, a0, a1;
            a_w = reg_addr_t'($urandom_range(0, 7));
            a_r = reg_addr_t'($urandom_range(0, 7));
            a0  = ($urandom_range(0, 3) == 0) ? reg_addr_t'($urandom_range(0, 31)) : reg_addr_t'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : reg_addr_t'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), a_w, $urandom, 1'($urandom_range(0, 1)), a_r, a0, a1);
            @(negedge clk);
            chk($sformatf("rand%0d rd0", n), rd[31:0], exp_rd(a0));
            chk($sformatf("rand%0d rd1", n), rd[63:32], exp_rd(a1));
            chk($sformatf("rand%0d rbusy", n), {30'h0, rbusy}, {30'h0, exp_busy(a1), exp_busy(a0)});
            tick();
        end

        // Reset in mid-run, between clock edges, with a write and a reserve pending.
        drive(1, 5, 32'h5A5A0005, 0, 0, 1, 2);
        tick();
        drive(1, 5, 32'h00000123, 1, 3, 5, 3);
        @(negedge clk);
        chk("pre-reset rd0", rd[31:0], BYP ? 32'h00000123 : 32'h5A5A0005);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset rd0", rd[31:0], 32'h0);
        chk("async reset rd1", rd[63:32], 32'h0);
        chk("async reset rbusy", {30'h0, rbusy}, 32'h0);
        @(posedge clk);
        #1;
        model_clear();
        drive(0, 0, 0, 0, 0, 5, 3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset reg5", rd[31:0], 32'h0);
        chk("post-reset reg3", rd[63:32], 32'h0);
        chk("post-reset rbusy", {30'h0, rbusy}, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
